sbox_sched: RTL and testbench

Time-multiplexes one shared DES S-box lookup port across the eight S-box substitutions of a DES round.
- Accepts a 48-bit word (expansion output XOR round key) through a valid/ready handshake.
- Issues eight 6-bit lookups, S1 through S8, one per cycle, and packs the 4-bit results into the 32-bit round-function pre-permutation word.
- Sits between the key-mix XOR and the P-permutation; the external S-box bank decodes row and column from the raw 6 bits.

---
 rtl/sbox_sched.sv | 101 ++++++++++
 tb/tb_sbox_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_sched.sv
// sbox_sched: issues the eight DES S-box lookups of a round over one shared port and packs the results; SBOX_SCHED_ABORT_EN adds an abort input
module sbox_sched #(
   parameter int SBOX_LAT = 0
) (
   input  logic        clk,
   input  logic        rst,
`ifdef SBOX_SCHED_ABORT_EN
   input  logic        abort,
`endif
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] data_in,
   output logic        sbox_req,
   output logic [2:0]  sbox_sel,
   output logic [5:0]  sbox_in,
   input  logic [3:0]  sbox_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] data_out
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t      state_q;
   logic [2:0]  idx_q, sbox_sel_q, idx_d, slot_d;
   logic [47:0] latch_q;
   logic        in_ready_q, sbox_req_q, out_valid_q, abort_d, cap_d;
   logic [5:0]  sbox_in_q, in_base_d;
   logic [31:0] data_out_q;
   logic [4:0]  out_base_d;
`ifdef SBOX_SCHED_ABORT_EN
   assign abort_d = abort && state_q != IDLE;
`else
   assign abort_d = 1'b0;
`endif
   assign in_ready  = in_ready_q;
   assign sbox_req  = sbox_req_q;
   assign sbox_sel  = sbox_sel_q;
   assign sbox_in   = sbox_in_q;
   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;
   // next issue index, which result slot sbox_out belongs to this cycle, and the bit offsets of both
   always_comb begin
      idx_d      = idx_q + 3'd1;
      slot_d     = SBOX_LAT == 0 ? idx_q : idx_q - 3'd1;
      cap_d      = SBOX_LAT == 0 ? state_q == ISSUE : (state_q == ISSUE && idx_q != 3'd0) || state_q == DRAIN;
      out_base_d = {~slot_d, 2'b00};
      in_base_d  = {3'b000, ~idx_d} * 6'd6;
   end
   // scheduler FSM with every output registered; abort wins over capture and handshakes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         latch_q     <= '0;
         in_ready_q  <= 1'b1;
         sbox_req_q  <= 1'b0;
         sbox_sel_q  <= '0;
         sbox_in_q   <= '0;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
      end else if (abort_d) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         sbox_req_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (cap_d) data_out_q[out_base_d +: 4] <= sbox_out;
         case (state_q)
            IDLE: if (in_valid) begin
               state_q    <= ISSUE;
               idx_q      <= '0;
               latch_q    <= data_in;
               in_ready_q <= 1'b0;
               sbox_req_q <= 1'b1;
               sbox_sel_q <= '0;
               sbox_in_q  <= data_in[47:42];
            end
            ISSUE: begin
               idx_q <= idx_d;
               if (idx_q == 3'd7) begin
                  state_q     <= SBOX_LAT == 0 ? DONE : DRAIN;
                  sbox_req_q  <= 1'b0;
                  out_valid_q <= SBOX_LAT == 0;
               end else begin
                  sbox_sel_q <= idx_d;
                  sbox_in_q  <= latch_q[in_base_d +: 6];
               end
            end
            DRAIN: begin
               state_q     <= DONE;
               out_valid_q <= 1'b1;
            end
            DONE: if (out_ready) begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sbox_sched.sv
// tb_sbox_sched: scoreboard bench driving a combinational-bank and a registered-bank scheduler one at a time
module tb_sbox_sched;
   logic clk = 1'b0;
   logic rst;
   logic [1:0] in_valid, out_ready;
   logic [1:0][47:0] data_in;
   logic [1:0][3:0] sbox_out;
   logic [3:0] bank1_q;
   wire [1:0] in_ready, sbox_req, out_valid;
   wire [1:0][2:0] sbox_sel;
   wire [1:0][5:0] sbox_in;
   wire [1:0][31:0] data_out;
`ifdef SBOX_SCHED_ABORT_EN
   logic [1:0] abort;
`endif
   logic [31:0] sb_q[$];
   int n_chk = 0, n_fail = 0, ncyc = 0;
   int cyc[2], req_cnt[2], acc_prev[2], acc_last[2];
   logic [47:0] cur[2];
   logic [1:0] busy = '0, ov_q = '0;

   always #5 clk = ~clk;

   function automatic logic [3:0] des_sbox(input logic [2:0] s, input logic [5:0] x);
      logic [255:0] t;
      int i;
      case (s)
         3'd0: t = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
         3'd1: t = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
         3'd2: t = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
         3'd3: t = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
         3'd4: t = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
         3'd5: t = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
         3'd6: t = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
         default: t = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
      endcase
      i = {26'd0, x[5], x[0], x[4:1]};
      return t[255 - 4 * i -: 4];
   endfunction

   function automatic logic [5:0] slice6(input logic [47:0] d, input int i);
      return d[47 - 6 * i -: 6];
   endfunction

   function automatic logic [31:0] model(input logic [47:0] d);
      logic [31:0] r;
      for (int i = 0; i < 8; i++) r[31 - 4 * i -: 4] = des_sbox(3'(i), slice6(d, i));
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sbox_sched #(.SBOX_LAT(g)) u_dut (
         .clk(clk), .rst(rst),
`ifdef SBOX_SCHED_ABORT_EN
         .abort(abort[g]),
`endif
         .in_valid(in_valid[g]), .in_ready(in_ready[g]), .data_in(data_in[g]),
         .sbox_req(sbox_req[g]), .sbox_sel(sbox_sel[g]), .sbox_in(sbox_in[g]), .sbox_out(sbox_out[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .data_out(data_out[g]));
   end

   // registered S-box bank for the SBOX_LAT=1 instance; junk when no lookup was issued
   always_ff @(posedge clk) bank1_q <= sbox_req[1] ? des_sbox(sbox_sel[1], sbox_in[1]) : 4'($urandom);
   // combinational S-box bank for the SBOX_LAT=0 instance; inverted result when no lookup is issued
   always_comb begin
      sbox_out[0] = sbox_req[0] ? des_sbox(sbox_sel[0], sbox_in[0]) : ~des_sbox(sbox_sel[0], sbox_in[0]);
      sbox_out[1] = bank1_q;
   end

   // monitor: lookup sequence, latency and scoreboard pop on each rising out_valid
   always @(negedge clk) begin
      ncyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            busy[k] = 1'b0;
            ov_q[k] = 1'b0;
         end else begin
            if (busy[k]) cyc[k]++;
            if (in_valid[k] && in_ready[k]) begin
               busy[k] = 1'b1;
               cyc[k] = 0;
               req_cnt[k] = 0;
               cur[k] = data_in[k];
               acc_prev[k] = acc_last[k];
               acc_last[k] = ncyc;
            end else if (sbox_req[k]) begin
               chk("sbox_sel", sbox_sel[k], req_cnt[k] & 7);
               chk("sbox_in", sbox_in[k], slice6(cur[k], req_cnt[k] & 7));
               req_cnt[k]++;
            end
            if (out_valid[k] && !ov_q[k]) begin
               chk("latency", cyc[k], 9 + k);
               chk("req_cycles", req_cnt[k], 8);
               chk("sb_nonempty", sb_q.size() != 0, 1);
               if (sb_q.size() != 0) chk("data_out", data_out[k], sb_q.pop_front());
               busy[k] = 1'b0;
            end
            ov_q[k] = out_valid[k];
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input int k);
      chk("rst_in_ready", in_ready[k], 1);
      chk("rst_out_valid", out_valid[k], 0);
      chk("rst_data_out", data_out[k], 0);
      chk("rst_sbox_req", sbox_req[k], 0);
      chk("rst_sbox_sel", sbox_sel[k], 0);
      chk("rst_sbox_in", sbox_in[k], 0);
   endtask

   task automatic send(input int k, input logic [47:0] d, input logic [31:0] e, input bit push);
      int t = 0;
      in_valid[k] = 1'b1;
      data_in[k] = d;
      while (!in_ready[k] && t < 50) begin
         step();
         t++;
      end
      chk("accept_timeout", t < 50, 1);
      if (push) sb_q.push_back(e);
      step();
      in_valid[k] = 1'b0;
   endtask

   task automatic wait_valid(input int k);
      int t = 0;
      while (!out_valid[k] && t < 100) begin
         step();
         t++;
      end
      chk("out_valid_timeout", t < 100, 1);
   endtask

   task automatic wait_done(input int k);
      wait_valid(k);
      step();
      chk("ready_after_done", in_ready[k], 1);
      chk("valid_after_done", out_valid[k], 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rnd;
      logic [47:0] d;
      logic [31:0] held;
      int t;
      rst = 1'b1;
      in_valid = '0;
      out_ready = '0;
      data_in = '0;
`ifdef SBOX_SCHED_ABORT_EN
      abort = '0;
`endif
      repeat (3) step();
      for (int k = 0; k < 2; k++) chk_reset(k);
      rst = 1'b0;
      out_ready = 2'b11;
      for (int k = 0; k < 2; k++) begin
         send(k, 48'h0, 32'hEFA72C4D, 1);
         wait_done(k);
         send(k, {48{1'b1}}, 32'hD9CE3DCB, 1);
         wait_done(k);
      end
      for (int k = 0; k < 2; k++) begin
         send(k, 48'h0, 32'hEFA72C4D, 1);
         send(k, {48{1'b1}}, 32'hD9CE3DCB, 1);
         chk("b2b_period", acc_last[k] - acc_prev[k], 10 + k);
         wait_done(k);
      end
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 3; j++) begin
            rnd = {$urandom, $urandom};
            d = rnd[47:0];
            out_ready[k] = 1'b0;
            send(k, d, model(d), 1);
            in_valid[k] = 1'b1;
            data_in[k] = ~d;
            wait_valid(k);
            held = data_out[k];
            repeat (j == 0 ? 5 : $urandom_range(0, 3)) begin
               step();
               chk("bp_valid", out_valid[k], 1);
               chk("bp_data", data_out[k], held);
               chk("bp_in_ready", in_ready[k], 0);
            end
            in_valid[k] = 1'b0;
            out_ready[k] = 1'b1;
            step();
            chk("bp_release_ready", in_ready[k], 1);
            chk("bp_release_valid", out_valid[k], 0);
            chk("bp_data_retained", data_out[k], held);
         end
      end
      for (int k = 0; k < 2; k++) begin
         send(k, 48'h123456789ABC, model(48'h123456789ABC), 1);
         t = 0;
         while (!(sbox_req[k] && sbox_sel[k] == 3'd4) && t < 20) begin
            step();
            t++;
         end
         chk("rst_reach_idx4", t < 20, 1);
         #2 rst = 1'b1;
         #1;
         chk_reset(0);
         chk_reset(1);
         sb_q.delete();
         step();
         rst = 1'b0;
         send(k, 48'h0, 32'hEFA72C4D, 1);
         wait_done(k);
      end
`ifdef SBOX_SCHED_ABORT_EN
      for (int k = 0; k < 2; k++) begin
         send(k, 48'hA5A5F00F1234, 32'h0, 0);
         t = 0;
         while (!(sbox_req[k] && sbox_sel[k] == 3'd3) && t < 20) begin
            step();
            t++;
         end
         chk("abort_reach_idx3", t < 20, 1);
         held = data_out[k];
         abort[k] = 1'b1;
         step();
         abort[k] = 1'b0;
         chk("abort_req", sbox_req[k], 0);
         chk("abort_valid", out_valid[k], 0);
         chk("abort_ready", in_ready[k], 1);
         chk("abort_data", data_out[k], held);
         repeat (12) begin
            step();
            chk("abort_no_valid", out_valid[k], 0);
         end
         abort[k] = 1'b1;
         send(k, {48{1'b1}}, 32'hD9CE3DCB, 1);
         abort[k] = 1'b0;
         wait_done(k);
      end
`endif
      repeat (3) step();
      chk("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
